// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler
//   Shares one WIDTH-bit gate unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among
//   NUM_REQ requesters. Arbitration is round-robin and only one operation
//   is in flight at a time. Each result comes back tagged with the ID of
//   the requester that issued it.
//
//   Ports:
//     clk, rst   rising-edge clock, synchronous active-high reset
//     req        per-requester request, held until that requester's gnt
//     op/a/b     per-requester opcode (3b) and operands, packed by index
//     gnt        one-hot grant pulse, only ever driven in IDLE
//     busy       high while the latched op is being computed (EXEC)
//     res_valid  one-cycle result strobe (RESP)
//     res_id     requester index of the result, held until the next result
//     res_data   result value, held until the next result
//     res_err    (GATE_SCHED_OPERR_EN only) flags the reserved opcode 7,
//                asserted together with res_valid
//
//   Optional feature macro: GATE_SCHED_OPERR_EN
//
//   One op takes 3 cycles: IDLE (grant) -> EXEC -> RESP (res_valid).
module gate_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*3-1:0]       op,
  input  logic [NUM_REQ*WIDTH-1:0]   a,
  input  logic [NUM_REQ*WIDTH-1:0]   b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       res_valid,
  output logic [ID_W-1:0]            res_id,
  output logic [WIDTH-1:0]           res_data
`ifdef GATE_SCHED_OPERR_EN
  ,
  output logic                       res_err
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } gate_req_t;

  localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ-1);
  localparam logic [2:0]      OP_RSVD = 3'd7;

  state_t    state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_id;
  gate_req_t lat;

  // Per-requester views of the flat input buses. Packed layout matches
  // the flat slicing, so lane i sits at [i].
  logic [NUM_REQ-1:0][2:0]       op_v;
  logic [NUM_REQ-1:0][WIDTH-1:0] a_v;
  logic [NUM_REQ-1:0][WIDTH-1:0] b_v;
  assign op_v = op;
  assign a_v  = a;
  assign b_v  = b;

  // Round-robin pick: the first asserted req at or after rr_ptr, wrapping.
  // The candidate index is one bit wider than an ID so the sum can exceed
  // NUM_REQ-1 before it is folded back into range.
  logic [ID_W-1:0] sel;
  logic            found;
  logic [ID_W:0]   cand;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[ID_W-1:0];
      end
    end
  end

  // The grant is combinational so the requester sees it in the same
  // cycle that its operands are latched.
  always_comb begin
    gnt = '0;
    if (state == IDLE && found) gnt[sel] = 1'b1;
  end

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (o)
      3'd0:    gate_f = x & y;
      3'd1:    gate_f = x | y;
      3'd2:    gate_f = ~x;
      3'd3:    gate_f = ~(x & y);
      3'd4:    gate_f = ~(x | y);
      3'd5:    gate_f = x ^ y;
      3'd6:    gate_f = ~(x ^ y);
      default: gate_f = '0;   // reserved opcode 7
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel_id    <= '0;
      lat       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
`ifdef GATE_SCHED_OPERR_EN
      res_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            lat    <= '{op: op_v[sel], a: a_v[sel], b: b_v[sel]};
            sel_id <= sel;
            rr_ptr <= (sel == LAST_ID) ? '0 : sel + ID_W'(1);
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_valid <= 1'b1;
          res_id    <= sel_id;
          res_data  <= gate_f(lat.op, lat.a, lat.b);
`ifdef GATE_SCHED_OPERR_EN
          res_err   <= (lat.op == OP_RSVD);
`endif
          busy      <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          // res_id and res_data are left alone so they hold until the
          // next result.
          res_valid <= 1'b0;
`ifdef GATE_SCHED_OPERR_EN
          res_err   <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef GATE_SCHED_OPERR_EN
  // Opcode 7 still resolves to zero data through gate_f. Only the flag is
  // absent in this build.
  logic unused_rsvd;
  assign unused_rsvd = (lat.op == OP_RSVD);
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
module tb_gate_op_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*3-1:0]     op;
  logic [NUM_REQ*WIDTH-1:0] a, b;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy, res_valid;
  logic [ID_W-1:0]          res_id;
  logic [WIDTH-1:0]         res_data;
`ifdef GATE_SCHED_OPERR_EN
  logic                     res_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  gate_op_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data)
`ifdef GATE_SCHED_OPERR_EN
    , .res_err(res_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Waits (bounded) for a grant pulse. Returns the granted index and the
  // cycle number it appeared in, or -1 on timeout.
  task automatic wait_gnt(output int idx, output int at);
    idx = -1;
    at  = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) idx = i;
        at = cyc;
        chk("gnt_onehot", $countones(gnt), 1);
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  // A single request/response transaction on requester i. When chg is
  // set, operand a is zeroed right after the grant.
  task automatic do_op(input int i, input logic [2:0] o, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] expd,
                       input bit chg);
    int g, t;
    @(posedge clk); #1;
    op[3*i +: 3]         = o;
    a[WIDTH*i +: WIDTH]  = av;
    b[WIDTH*i +: WIDTH]  = bv;
    req[i]               = 1'b1;
    wait_gnt(g, t);
    chk("gnt_id", g, i);
    @(posedge clk); #1;
    req[i] = 1'b0;
    if (chg) a[WIDTH*i +: WIDTH] = '0;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_noval", res_valid, 0);
    chk("exec_gnt0", gnt, 0);
    @(negedge clk);
    chk("resp_valid", res_valid, 1);
    chk("resp_id", res_id, i);
    chk("resp_data", res_data, expd);
    chk("resp_busy0", busy, 0);
`ifdef GATE_SCHED_OPERR_EN
    chk("resp_err", res_err, 32'(o == 3'd7));
`endif
    @(negedge clk);
    chk("idle_noval", res_valid, 0);
    chk("idle_hold", res_data, expd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] sweep [8];
    int g, t, prev;
    sweep = '{8'h88, 8'hEE, 8'h33, 8'h77, 8'h11, 8'h66, 8'h99, 8'h00};
    rst = 1'b1; req = '0; op = '0; a = '0; b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_data", res_data, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Reset while EXEC: the op is aborted
    op[2:0] = 3'd0; a[7:0] = 8'hF0; b[7:0] = 8'h3C; req[0] = 1'b1;
    wait_gnt(g, t);
    chk("abort_gnt", g, 0);
    @(posedge clk); #1; rst = 1'b1; req = '0;
    @(negedge clk);
    chk("abort_exec_busy", busy, 1);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_noval", res_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_gnt0", gnt, 0);
    end

    // Single request, XOR
    do_op(1, 3'd5, 8'hAA, 8'h0F, 8'hA5, 1'b0);

    // Operand change after grant has no effect
    do_op(2, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b1);

    // Opcode sweep
    for (int o = 0; o < 8; o++) do_op(2, 3'(o), 8'hCC, 8'hAA, sweep[o], 1'b0);

    // Round robin with all four requesting (pointer reset to 0 first)
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    op = {4{3'd1}}; a = 32'h01020408; b = 32'h10204080;
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, t);
      chk("rr_order", g, k % NUM_REQ);
      if (k > 0) chk("rr_gap", t - prev, 3);
      prev = t;
      if (k == 4) begin
        @(posedge clk); #1; req = '0;
      end
    end
    repeat (3) @(posedge clk);

    // Pointer wrap: grant 3, then 0 and 3 both request
    do_op(3, 3'd6, 8'h0F, 8'h33, 8'hC3, 1'b0);
    @(posedge clk); #1; req = 4'b1001;
    wait_gnt(g, t);
    chk("wrap_first", g, 0);
    prev = t;
    @(posedge clk); #1; req[0] = 1'b0;
    wait_gnt(g, t);
    chk("wrap_second", g, 3);
    chk("wrap_gap", t - prev, 3);
    @(posedge clk); #1; req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_resp_id", res_id, 3);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
